// File: rtl/bcd_stopwatch_if.sv
// Stopwatch control and display bundle.
// The master drives tick/run/clear and watches the digits; the stopwatch is the slave.
interface bcd_stopwatch_if;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;

    modport master (
        output tick_in,
        output start_stop,
        output clear,
        input  sec_ones,
        input  sec_tens,
        input  min_ones,
        input  min_tens,
        input  running,
        input  wrap
    );

    modport slave (
        input  tick_in,
        input  start_stop,
        input  clear,
        output sec_ones,
        output sec_tens,
        output min_ones,
        output min_tens,
        output running,
        output wrap
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch advanced by edges of a slow tick square wave.
//
//  state  | meaning
//  IDLE   | stopped after reset/clear, waiting for first start_stop rise
//  RUN    | counting one second per tick step
//  PAUSED | digits frozen, next start_stop rise resumes counting
module bcd_stopwatch #(
    parameter int unsigned RISE_ONLY = 1
) (
    input  logic            clk_in,
    input  logic            reset,
    bcd_stopwatch_if.slave  sw
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       tick_q;
    logic       ss_q;
    logic       step;
    logic       ss_rise;
    logic       count_en;
    logic       at_max;

    logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
    logic [3:0] sec_ones_n, sec_tens_n, min_ones_n, min_tens_n;
    logic       wrap_q;
    logic       wrap_n;

    // Previous-cycle copies of tick_in and start_stop for edge detection.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            tick_q <= 1'b0;
            ss_q   <= 1'b0;
        end else begin
            tick_q <= sw.tick_in;
            ss_q   <= sw.start_stop;
        end
    end

    generate
        if (RISE_ONLY != 0) begin : g_rise_only
            assign step = sw.tick_in & ~tick_q;
        end else begin : g_both_edges
            assign step = sw.tick_in ^ tick_q;
        end
    endgenerate

    assign ss_rise = sw.start_stop & ~ss_q;

    // Counting is gated by the state before the edge, so a step that
    // coincides with leaving RUN still counts and one entering RUN does not.
    assign count_en = step & (state == RUN) & ~sw.clear;

    assign at_max = (sec_ones_q >= 4'd9) && (sec_tens_q >= 4'd5) &&
                    (min_ones_q >= 4'd9) && (min_tens_q >= 4'd5);

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: clear wins over any start_stop rise.
    always_comb begin
        state_next = state;
        if (sw.clear) begin
            state_next = IDLE;
        end else if (ss_rise) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSED;
                PAUSED:  state_next = RUN;
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE && state != RUN && state != PAUSED) begin
            state_next = IDLE;
        end
    end

    // BCD ripple increment; a digit at or beyond its top value rolls to zero
    // and carries, which also pulls any out-of-range value back into range.
    always_comb begin
        sec_ones_n = sec_ones_q;
        sec_tens_n = sec_tens_q;
        min_ones_n = min_ones_q;
        min_tens_n = min_tens_q;
        wrap_n     = 1'b0;
        if (sw.clear) begin
            sec_ones_n = 4'd0;
            sec_tens_n = 4'd0;
            min_ones_n = 4'd0;
            min_tens_n = 4'd0;
        end else if (count_en) begin
            wrap_n = at_max;
            if (sec_ones_q >= 4'd9) begin
                sec_ones_n = 4'd0;
                if (sec_tens_q >= 4'd5) begin
                    sec_tens_n = 4'd0;
                    if (min_ones_q >= 4'd9) begin
                        min_ones_n = 4'd0;
                        if (min_tens_q >= 4'd5) begin
                            min_tens_n = 4'd0;
                        end else begin
                            min_tens_n = min_tens_q + 4'd1;
                        end
                    end else begin
                        min_ones_n = min_ones_q + 4'd1;
                    end
                end else begin
                    sec_tens_n = sec_tens_q + 4'd1;
                end
            end else begin
                sec_ones_n = sec_ones_q + 4'd1;
            end
        end
    end

    // Digit and wrap-pulse registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            wrap_q     <= 1'b0;
        end else begin
            sec_ones_q <= sec_ones_n;
            sec_tens_q <= sec_tens_n;
            min_ones_q <= min_ones_n;
            min_tens_q <= min_tens_n;
            wrap_q     <= wrap_n;
        end
    end

    assign sw.sec_ones = sec_ones_q;
    assign sw.sec_tens = sec_tens_q;
    assign sw.min_ones = min_ones_q;
    assign sw.min_tens = min_tens_q;
    assign sw.running  = (state == RUN);
    assign sw.wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: one rise-only instance and one both-edge instance.
module tb_bcd_stopwatch;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;

    int checks   = 0;
    int failures = 0;
    int wrap_cnt = 0;
    logic run_dropped;

    bcd_stopwatch_if sw1 ();
    bcd_stopwatch_if sw2 ();

    bcd_stopwatch #(.RISE_ONLY(1)) dut1 (
        .clk_in (clk_in),
        .reset  (reset),
        .sw     (sw1.slave)
    );

    bcd_stopwatch #(.RISE_ONLY(0)) dut2 (
        .clk_in (clk_in),
        .reset  (reset2),
        .sw     (sw2.slave)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] digits1();
        return {sw1.min_tens, sw1.min_ones, sw1.sec_tens, sw1.sec_ones};
    endfunction

    function automatic logic [15:0] digits2();
        return {sw2.min_tens, sw2.min_ones, sw2.sec_tens, sw2.sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock, then sample 1 ns after the edge.
    task automatic cyc();
        @(posedge clk_in);
        #1;
        if (sw1.wrap === 1'b1) wrap_cnt++;
    endtask

    task automatic tick1();
        sw1.tick_in = 1'b1;
        cyc();
        sw1.tick_in = 1'b0;
        cyc();
    endtask

    task automatic ticks1(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    task automatic ss_pulse1();
        sw1.start_stop = 1'b1;
        cyc();
        sw1.start_stop = 1'b0;
        cyc();
    endtask

    task automatic reset1();
        reset = 1'b1;
        sw1.tick_in = 1'b0;
        sw1.start_stop = 1'b0;
        sw1.clear = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        sw1.tick_in = 1'b0; sw1.start_stop = 1'b0; sw1.clear = 1'b0;
        sw2.tick_in = 1'b0; sw2.start_stop = 1'b0; sw2.clear = 1'b0;

        // reset state
        reset1();
        check("rst_digits", digits1(), 16'h0000);
        check("rst_running", sw1.running, 0);
        check("rst_wrap", sw1.wrap, 0);

        // basic count: 75 ticks -> 01:15
        ss_pulse1();
        check("basic_run", sw1.running, 1);
        wrap_cnt = 0;
        ticks1(75);
        check("basic_digits", digits1(), 16'h0115);
        check("basic_running", sw1.running, 1);
        check("basic_no_wrap", wrap_cnt, 0);

        // wrap: 3599 steps -> 59:59, one more -> 00:00 with single wrap pulse
        reset1();
        ss_pulse1();
        wrap_cnt = 0;
        ticks1(3599);
        check("wrap_5959", digits1(), 16'h5959);
        check("wrap_none_yet", wrap_cnt, 0);
        sw1.tick_in = 1'b1;
        cyc();
        check("wrap_digits", digits1(), 16'h0000);
        check("wrap_pulse", sw1.wrap, 1);
        check("wrap_running", sw1.running, 1);
        sw1.tick_in = 1'b0;
        cyc();
        check("wrap_pulse_end", sw1.wrap, 0);
        check("wrap_once", wrap_cnt, 1);
        tick1();
        check("wrap_resume", digits1(), 16'h0001);

        // pause / resume
        reset1();
        ss_pulse1();
        ticks1(7);
        check("pause_pre", digits1(), 16'h0007);
        ss_pulse1();
        check("pause_running", sw1.running, 0);
        ticks1(10);
        check("pause_held", digits1(), 16'h0007);
        ss_pulse1();
        check("resume_running", sw1.running, 1);
        ticks1(3);
        check("resume_digits", digits1(), 16'h0010);

        // clear priority at 12:34
        reset1();
        ss_pulse1();
        ticks1(754);
        check("clr_pre", digits1(), 16'h1234);
        sw1.tick_in = 1'b1;
        sw1.start_stop = 1'b1;
        sw1.clear = 1'b1;
        cyc();
        check("clr_digits", digits1(), 16'h0000);
        check("clr_running", sw1.running, 0);
        check("clr_wrap", sw1.wrap, 0);
        sw1.tick_in = 1'b0;
        sw1.start_stop = 1'b0;
        sw1.clear = 1'b0;
        cyc();
        ticks1(2);
        check("clr_idle_hold", digits1(), 16'h0000);

        // held start_stop: RUN entered once
        reset1();
        sw1.start_stop = 1'b1;
        cyc();
        check("held_enter", sw1.running, 1);
        run_dropped = 1'b0;
        for (int i = 0; i < 19; i++) begin
            cyc();
            if (sw1.running !== 1'b1) run_dropped = 1'b1;
        end
        check("held_no_toggle", run_dropped, 0);
        sw1.start_stop = 1'b0;
        cyc();
        tick1();
        check("held_counts", digits1(), 16'h0001);

        // step coincident with leaving RUN counts
        sw1.tick_in = 1'b1;
        sw1.start_stop = 1'b1;
        cyc();
        check("leave_run_counts", digits1(), 16'h0002);
        check("leave_run_paused", sw1.running, 0);
        sw1.tick_in = 1'b0;
        sw1.start_stop = 1'b0;
        cyc();
        // step coincident with entering RUN does not count
        sw1.tick_in = 1'b1;
        sw1.start_stop = 1'b1;
        cyc();
        check("enter_run_nocount", digits1(), 16'h0002);
        check("enter_run_running", sw1.running, 1);
        sw1.tick_in = 1'b0;
        sw1.start_stop = 1'b0;
        cyc();
        tick1();
        check("enter_run_then", digits1(), 16'h0003);

        // tick_in high through reset: first cycle is an edge, but IDLE ignores it
        reset = 1'b1;
        sw1.tick_in = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        sw1.start_stop = 1'b1;
        cyc();
        check("post_rst_edge_digits", digits1(), 16'h0000);
        check("post_rst_running", sw1.running, 1);
        sw1.tick_in = 1'b0;
        sw1.start_stop = 1'b0;
        cyc();
        tick1();
        check("post_rst_count", digits1(), 16'h0001);

        // mid-count reset on the rise-only instance
        ticks1(5);
        reset = 1'b1;
        cyc();
        check("midrst1_digits", digits1(), 16'h0000);
        check("midrst1_running", sw1.running, 0);
        reset = 1'b0;

        // both-edge instance: 10 periods -> 00:20, then mid-count reset
        reset2 = 1'b1;
        cyc();
        cyc();
        reset2 = 1'b0;
        check("both_rst_digits", digits2(), 16'h0000);
        sw2.start_stop = 1'b1;
        cyc();
        sw2.start_stop = 1'b0;
        cyc();
        check("both_running", sw2.running, 1);
        for (int i = 0; i < 10; i++) begin
            sw2.tick_in = 1'b1;
            cyc();
            sw2.tick_in = 1'b0;
            cyc();
        end
        check("both_digits", digits2(), 16'h0020);
        sw2.tick_in = 1'b1;
        cyc();
        check("both_half", digits2(), 16'h0021);
        reset2 = 1'b1;
        cyc();
        check("both_midrst_digits", digits2(), 16'h0000);
        check("both_midrst_running", sw2.running, 0);
        reset2 = 1'b0;
        sw2.tick_in = 1'b0;
        cyc();
        check("both_after_rst_idle", digits2(), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
